// File: rtl/mul_if.sv
// Multiplier request / write-back bundle.
// Operands flow in with start; result leaves as a register file write.
interface mul_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             accumulate;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_in;
  logic [3:0]       dest;
  logic             busy;
  logic             done;
  logic             we3;
  logic [3:0]       wa3;
  logic [WIDTH-1:0] wd3;
  logic             n_flag;
  logic             z_flag;

  modport master (
    output start, accumulate, a, b, acc_in, dest,
    input  busy, done, we3, wa3, wd3, n_flag, z_flag
  );

  modport slave (
    input  start, accumulate, a, b, acc_in, dest,
    output busy, done, we3, wa3, wd3, n_flag, z_flag
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit, one multiplier bit per cycle.
// Result is returned as a single-cycle register file write request.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  reset,
  mul_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       dest_q, dest_d;

  // Next-state and datapath update for capture and iteration
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = bus.accumulate ? bus.acc_in : '0;
          dest_d   = bus.dest;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
    end
  end

  logic in_done;
  assign in_done = (state_q == DONE);

  // R15 is the PC and is never written through this port
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = in_done;
  assign bus.we3    = in_done && (dest_q != 4'hF);
  assign bus.wa3    = dest_q;
  assign bus.wd3    = acc_q;
  assign bus.n_flag = in_done && acc_q[WIDTH-1];
  assign bus.z_flag = in_done && (acc_q == '0);
endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit.
// Expected write-backs are queued on issue and matched on done.
module tb_mul_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_if #(.WIDTH(W)) bus ();

  mul_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] wd;
    logic [3:0]   wa;
    logic         we;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] ia, logic [W-1:0] ib,
                                 logic [W-1:0] iacc, logic iaccum,
                                 logic [3:0] id);
    exp_t e;
    e.wd = ia * ib + (iaccum ? iacc : '0);
    e.wa = id;
    e.we = (id != 4'hF);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.we3 && !bus.done) chk("we3_outside_done", 1, 0);
    if (bus.done) begin
      done_cnt++;
      last_done = cyc;
      if (sb.size() == 0) begin
        chk("extra_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wd3", bus.wd3, e.wd);
        chk("wa3", bus.wa3, e.wa);
        chk("we3", bus.we3, e.we);
        chk("n_flag", bus.n_flag, e.wd[W-1]);
        chk("z_flag", bus.z_flag, e.wd == '0);
        chk("busy_in_done", bus.busy, 0);
      end
    end
  endtask

  task automatic set_ops(logic [W-1:0] ia, logic [W-1:0] ib,
                         logic [W-1:0] iacc, logic iaccum,
                         logic [3:0] id);
    bus.a          = ia;
    bus.b          = ib;
    bus.acc_in     = iacc;
    bus.accumulate = iaccum;
    bus.dest       = id;
  endtask

  task automatic run_op(logic [W-1:0] ia, logic [W-1:0] ib,
                        logic [W-1:0] iacc, logic iaccum,
                        logic [3:0] id, bit poke);
    int d0;
    int bcnt;
    set_ops(ia, ib, iacc, iaccum, id);
    sb.push_back(model(ia, ib, iacc, iaccum, id));
    bus.start = 1'b1;
    d0 = done_cnt;
    tick();
    bus.start = 1'b0;
    bcnt = 0;
    while (bus.busy && bcnt < 100) begin
      bcnt++;
      if (poke && (bcnt == 5 || bcnt == 32)) begin
        set_ops(32'h1234, 32'h5678, 32'h1, 1'b1, 4'h9);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    chk("busy_len", bcnt, W);
    chk("done_at_latency", bus.done, 1);
    chk("done_pulses", done_cnt - d0, 1);
    if (poke) begin
      set_ops(32'h77, 32'h88, 32'h0, 1'b0, 4'h1);
      bus.start = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    chk("idle_after", {bus.busy, bus.done}, 0);
  endtask

  task automatic quiet(int n);
    int d0;
    bit busy_seen;
    d0 = done_cnt;
    busy_seen = 1'b0;
    repeat (n) begin
      tick();
      if (bus.busy) busy_seen = 1'b1;
    end
    chk("quiet_busy", busy_seen, 0);
    chk("quiet_done", done_cnt - d0, 0);
  endtask

  initial begin
    int d0;
    int t;
    int first;
    exp_t e;
    bus.start = 1'b0;
    set_ops('0, '0, '0, 1'b0, 4'h0);
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we3", bus.we3, 0);
    chk("rst_wa3", bus.wa3, 0);
    chk("rst_wd3", bus.wd3, 0);
    chk("rst_n", bus.n_flag, 0);
    chk("rst_z", bus.z_flag, 0);
    reset = 1'b0;
    tick();

    run_op(32'd7, 32'd6, 32'd0, 1'b0, 4'd3, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 1'b1, 4'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd2, 1'b0);
    run_op(32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 4'd8, 1'b0);
    run_op(32'd9, 32'd11, 32'd0, 1'b0, 4'd4, 1'b1);
    quiet(40);
    run_op(32'd2, 32'd2, 32'd0, 1'b0, 4'hF, 1'b0);

    set_ops(32'd100, 32'd200, 32'd0, 1'b0, 4'd5);
    sb.push_back(model(32'd100, 32'd200, 32'd0, 1'b0, 4'd5));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_wd3", bus.wd3, 0);
    reset = 1'b0;
    e = sb.pop_back();
    quiet(40);
    run_op(32'd3, 32'd5, 32'd0, 1'b0, 4'd6, 1'b0);

    set_ops(32'd13, 32'd17, 32'd100, 1'b1, 4'd7);
    e = model(32'd13, 32'd17, 32'd100, 1'b1, 4'd7);
    sb.push_back(e);
    sb.push_back(e);
    bus.start = 1'b1;
    d0 = done_cnt;
    t = 0;
    first = 0;
    while (done_cnt - d0 < 2 && t < 200) begin
      tick();
      t++;
      if (done_cnt - d0 == 1 && first == 0) first = cyc;
    end
    bus.start = 1'b0;
    chk("reissue_count", done_cnt - d0, 2);
    chk("reissue_gap", last_done - first, W + 2);
    tick();
    quiet(10);

    repeat (4) begin
      run_op($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 14)), 1'b0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
